// File: rtl/pipe_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_counters
// Description : Windowed pipeline performance counters. NUM_CH event counters
//               count while a measurement window is open. The window can end
//               after win_len cycles or on a stop pulse. A shadow bank captures
//               counter values at window end or on demand, and is read back
//               through a registered mux.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_counters #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 2
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [CNT_W-1:0]  win_len_i,
  input  logic              snap_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  win_len_q, win_len_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  logic              run_s;
  logic              win_last_s;
  logic              win_end_s;
  logic              shadow_load_s;

  // A bounded window closes on the edge where win_cnt reaches win_len-1, so
  // exactly win_len event-cycles are counted. win_len of zero never closes.
  assign run_s      = (state_q == ST_RUN);
  assign win_last_s = (win_len_q != CNT_ZERO) && (win_cnt_q == (win_len_q - CNT_ONE));

  // Next-state logic; start overrides everything, including a coincident stop
  always_comb begin
    state_d   = state_q;
    win_end_s = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_RUN: begin
        if (stop_i || win_last_s) begin
          state_d   = ST_DONE;
          win_end_s = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (start_i) begin
      state_d   = ST_RUN;
      win_end_s = 1'b0;
    end
  end

  // Counter, overflow and window bookkeeping next values
  always_comb begin
    win_cnt_d = win_cnt_q;
    win_len_d = win_len_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (start_i) begin
      // The start edge clears everything; its own events are not counted.
      win_cnt_d = CNT_ZERO;
      win_len_d = win_len_i;
      ovf_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_d[i] = CNT_ZERO;
      end
    end else if (run_s) begin
      // win_cnt wraps silently when the window is unbounded.
      win_cnt_d = win_cnt_q + CNT_ONE;
      for (int i = 0; i < NUM_CH; i++) begin
        if (event_i[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
          if (cnt_q[i] == '1) begin
            ovf_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // Shadow bank captures the post-update counter values. A snap coincident
  // with window end is a single load of the same values, and a snap
  // coincident with start captures the cleared (zero) counters.
  assign shadow_load_s = snap_i || win_end_s;

  // Shadow bank next values
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_load_s ? cnt_d[i] : shadow_q[i];
    end
  end

  // Readback mux; unpopulated select codes read as zero
  always_comb begin
    rd_data_d = CNT_ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_data_d = shadow_q[i];
      end
    end
  end

  // State register
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Event counters and shadow bank
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= CNT_ZERO;
        shadow_q[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Window counter, latched window length, sticky overflow flags, readback
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win_cnt_q <= CNT_ZERO;
      win_len_q <= CNT_ZERO;
      ovf_q     <= '0;
      rd_data_q <= CNT_ZERO;
    end else begin
      win_cnt_q <= win_cnt_d;
      win_len_q <= win_len_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pipe_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_perf_counters
// Description : Scoreboard bench for pipe_perf_counters. Two instances share
//               stimulus: a 32-bit one and an 8-bit one for wrap behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_perf_counters;

  localparam int K_RD32   = 0;
  localparam int K_OVF32  = 1;
  localparam int K_BUSY32 = 2;
  localparam int K_DONE32 = 3;
  localparam int K_RD8    = 4;
  localparam int K_OVF8   = 5;
  localparam int K_BUSY8  = 6;
  localparam int K_DONE8  = 7;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ev;
  logic        start;
  logic        stop;
  logic [31:0] win_len;
  logic        snap;
  logic [1:0]  rd_sel;

  logic [31:0] rd32;
  logic [3:0]  ovf32;
  logic        busy32, done32;
  logic [7:0]  rd8;
  logic [3:0]  ovf8;
  logic        busy8, done8;

  chk_t sb_q[$];
  event sample_ev;
  int   total = 0;
  int   bad   = 0;

  pipe_perf_counters #(.NUM_CH(4), .CNT_W(32), .SEL_W(2)) u_dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .event_i   (ev),
    .start_i   (start),
    .stop_i    (stop),
    .win_len_i (win_len),
    .snap_i    (snap),
    .rd_sel_i  (rd_sel),
    .rd_data_o (rd32),
    .ovf_o     (ovf32),
    .busy_o    (busy32),
    .done_o    (done32)
  );

  pipe_perf_counters #(.NUM_CH(4), .CNT_W(8), .SEL_W(2)) u_dut8 (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .event_i   (ev),
    .start_i   (start),
    .stop_i    (stop),
    .win_len_i (win_len[7:0]),
    .snap_i    (snap),
    .rd_sel_i  (rd_sel),
    .rd_data_o (rd8),
    .ovf_o     (ovf8),
    .busy_o    (busy8),
    .done_o    (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RD32:   return rd32;
      K_OVF32:  return {28'd0, ovf32};
      K_BUSY32: return {31'd0, busy32};
      K_DONE32: return {31'd0, done32};
      K_RD8:    return {24'd0, rd8};
      K_OVF8:   return {28'd0, ovf8};
      K_BUSY8:  return {31'd0, busy8};
      K_DONE8:  return {31'd0, done8};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  initial begin : monitor
    chk_t c;
    logic mism;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        c    = sb_q.pop_front();
        mism = 1'b1;
        case (c.kind)
          K_RD32:   mism = (rd32   !== c.exp);
          K_OVF32:  mism = (ovf32  !== c.exp[3:0]);
          K_BUSY32: mism = (busy32 !== c.exp[0]);
          K_DONE32: mism = (done32 !== c.exp[0]);
          K_RD8:    mism = (rd8    !== c.exp[7:0]);
          K_OVF8:   mism = (ovf8   !== c.exp[3:0]);
          K_BUSY8:  mism = (busy8  !== c.exp[0]);
          K_DONE8:  mism = (done8  !== c.exp[0]);
          default:  mism = 1'b1;
        endcase
        total++;
        if (mism) begin
          bad++;
          $display("FAIL %s: got %0d expected %0d", c.name, actual(c.kind), c.exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input int k, input logic [31:0] e, input string nm);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.name = nm;
    sb_q.push_back(c);
  endtask

  task automatic sample();
    -> sample_ev;
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; ev = '0; start = 0; stop = 0; win_len = '0; snap = 0; rd_sel = '0;
    cyc(2);
    expect_v(K_RD32, 0, "reset rd32");
    expect_v(K_OVF32, 0, "reset ovf32");
    expect_v(K_BUSY32, 0, "reset busy32");
    expect_v(K_DONE32, 0, "reset done32");
    expect_v(K_RD8, 0, "reset rd8");
    expect_v(K_BUSY8, 0, "reset busy8");
    sample();
    rst_n = 1'b1;
    cyc(1);

    // Bounded window of 10 cycles, channels 0 and 2 active every cycle
    start = 1; win_len = 10; ev = 4'b0101;
    cyc(1);
    start = 0;
    expect_v(K_BUSY32, 1, "t1 busy after start");
    expect_v(K_DONE32, 0, "t1 done after start");
    sample();
    cyc(9);
    expect_v(K_BUSY32, 1, "t1 busy at cycle 9");
    sample();
    cyc(1);
    expect_v(K_BUSY32, 0, "t1 busy at end");
    expect_v(K_DONE32, 1, "t1 done at end");
    sample();
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      cyc(1);
      expect_v(K_RD32, (s % 2 == 0) ? 32'd10 : 32'd0, $sformatf("t1 shadow[%0d]", s));
      sample();
    end

    // Unbounded window, 7 pulses on channel 1, stop with an 8th pulse on cycle 20
    ev = '0; win_len = 0; start = 1;
    cyc(1);
    start = 0;
    for (int c = 1; c <= 20; c++) begin
      ev   = (((c % 2 == 0) && (c <= 14)) || (c == 20)) ? 4'b0010 : 4'b0000;
      stop = (c == 20);
      cyc(1);
    end
    ev = '0; stop = 0;
    expect_v(K_DONE32, 1, "t2 done after stop");
    expect_v(K_BUSY32, 0, "t2 busy after stop");
    expect_v(K_OVF32, 0, "t2 ovf");
    sample();
    rd_sel = 0;
    cyc(1);
    expect_v(K_RD32, 0, "t2 shadow[0]");
    sample();
    rd_sel = 1;
    cyc(1);
    expect_v(K_RD32, 8, "t2 shadow[1]");
    sample();

    // Snap on the 5th run cycle while channel 0 counts continuously
    ev = 4'b0001; start = 1;
    cyc(1);
    start = 0;
    cyc(4);
    snap = 1;
    cyc(1);
    snap = 0;
    expect_v(K_RD32, 8, "t3 rd one cycle after snap");
    sample();
    rd_sel = 0;
    #1;
    expect_v(K_RD32, 8, "t3 rd right after sel change");
    sample();
    cyc(1);
    expect_v(K_RD32, 5, "t3 shadow[0] after sel change");
    sample();
    cyc(5);
    expect_v(K_RD32, 5, "t3 shadow[0] held while running");
    expect_v(K_BUSY32, 1, "t3 still running");
    sample();
    stop = 1;
    cyc(1);
    stop = 0;
    expect_v(K_DONE32, 1, "t3 done after stop");
    expect_v(K_RD32, 5, "t3 rd lags shadow load");
    sample();
    cyc(1);
    expect_v(K_RD32, 12, "t3 final count ch0");
    sample();

    // start and stop on the same edge while running
    ev = 4'b0001; start = 1;
    cyc(1);
    start = 0;
    cyc(3);
    start = 1; stop = 1;
    cyc(1);
    start = 0; stop = 0;
    expect_v(K_BUSY32, 1, "t4 busy after start+stop");
    expect_v(K_DONE32, 0, "t4 done after start+stop");
    sample();
    ev = '0; stop = 1;
    cyc(1);
    stop = 0;
    expect_v(K_DONE32, 1, "t4 done after stop");
    sample();
    cyc(1);
    expect_v(K_RD32, 0, "t4 counters cleared by start");
    sample();

    // win_len = 1, then snap coincident with start
    ev = 4'b1111; win_len = 1; rd_sel = 3; start = 1;
    cyc(1);
    start = 0;
    cyc(1);
    expect_v(K_DONE32, 1, "t5 done after 1 cycle");
    sample();
    cyc(1);
    expect_v(K_RD32, 1, "t5 shadow[3] win_len 1");
    sample();
    start = 1; snap = 1;
    cyc(1);
    start = 0; snap = 0;
    expect_v(K_BUSY32, 1, "t5 busy after start+snap");
    expect_v(K_RD32, 1, "t5 rd before zero load visible");
    sample();
    cyc(1);
    expect_v(K_RD32, 0, "t5 snap+start loads zeros");
    expect_v(K_DONE32, 1, "t5 done again");
    sample();
    cyc(1);
    expect_v(K_RD32, 1, "t5 shadow[3] second window");
    sample();

    // 8-bit wrap: channel 2 high for 258 counted cycles
    ev = 4'b0100; win_len = 0; start = 1;
    cyc(1);
    start = 0;
    cyc(257);
    stop = 1;
    cyc(1);
    stop = 0;
    expect_v(K_OVF8, 4, "t6 ovf8 after wrap");
    expect_v(K_DONE8, 1, "t6 done8");
    expect_v(K_OVF32, 0, "t6 ovf32 no wrap");
    sample();
    rd_sel = 2;
    cyc(1);
    expect_v(K_RD8, 2, "t6 shadow8[2]");
    expect_v(K_RD32, 258, "t6 shadow32[2]");
    sample();
    start = 1;
    cyc(1);
    start = 0;
    expect_v(K_OVF8, 0, "t6 ovf8 cleared by start");
    expect_v(K_BUSY8, 1, "t6 busy8");
    sample();

    // Asynchronous reset mid-run with live state everywhere
    cyc(260);
    snap = 1;
    cyc(1);
    snap = 0;
    cyc(1);
    expect_v(K_RD8, 5, "t7 rd8 before reset");
    expect_v(K_OVF8, 4, "t7 ovf8 before reset");
    expect_v(K_BUSY8, 1, "t7 busy8 before reset");
    sample();
    #2;
    rst_n = 1'b0;
    #1;
    expect_v(K_RD8, 0, "t7 rd8 async reset");
    expect_v(K_OVF8, 0, "t7 ovf8 async reset");
    expect_v(K_BUSY8, 0, "t7 busy8 async reset");
    expect_v(K_DONE8, 0, "t7 done8 async reset");
    expect_v(K_RD32, 0, "t7 rd32 async reset");
    expect_v(K_BUSY32, 0, "t7 busy32 async reset");
    sample();
    cyc(1);
    rst_n = 1'b1;
    stop = 1;
    cyc(1);
    stop = 0;
    expect_v(K_DONE32, 0, "t7 stop ignored in idle");
    expect_v(K_BUSY32, 0, "t7 idle after reset");
    expect_v(K_BUSY8, 0, "t7 idle8 after reset");
    sample();
    cyc(1);
    expect_v(K_RD8, 0, "t7 shadow8 cleared");
    sample();

    if (bad != 0 || total < 12) begin
      $display("FAIL summary: total=%0d bad=%0d", total, bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_perf_counters.md
PIPE_PERF_COUNTERS -- requirements
Module: pipe_perf_counters

Interface
REQ-001 Parameter NUM_CH, default 4: number of event counter channels, 1..16.
REQ-002 Parameter CNT_W, default 32: width of each event counter, the window counter and win_len, 8..32.
REQ-003 Parameter SEL_W, default 2: rd_sel width; SHALL equal ceil(log2(NUM_CH)), minimum 1.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 event  in  NUM_CH  per-channel event strobe, sampled every rising edge (e.g. stall, flush, branch-taken, retire).
REQ-008 start  in  1  single-cycle pulse; clear counters and begin a measurement window.
REQ-009 stop  in  1  single-cycle pulse; end the window early.
REQ-010 win_len  in  CNT_W  window length in cycles, sampled on start; 0 = unbounded.
REQ-011 snap  in  1  copy live counter values into the shadow bank without stopping.
REQ-012 rd_sel  in  SEL_W  shadow channel select.
REQ-013 rd_data  out  CNT_W  registered shadow[rd_sel].
REQ-014 ovf  out  NUM_CH  sticky per-channel wrap flags.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  high in DONE.

Function
REQ-017 FSM states: IDLE, RUN, DONE; busy/done decoded from state register only.
REQ-018 IDLE: start -> RUN; all other inputs except snap/rd_sel ignored.
REQ-019 Any state, start=1: at that edge counters, win_cnt and ovf clear to 0, win_len latched, state -> RUN; start dominates simultaneous stop.
REQ-020 RUN: counter i += 1 on each edge where event[i]=1; win_cnt += 1 every edge; event on the start edge is not counted.
REQ-021 Counters wrap modulo 2^CNT_W; ovf[i] sets on the edge counter i goes all-ones -> 0 and stays set until start or reset.
REQ-022 RUN, latched win_len != 0 and win_cnt == win_len-1: at that edge the final cycle's events are counted, shadow loads the post-update values, state -> DONE; exactly win_len event-cycles are counted.
REQ-023 RUN, stop=1 (no start): same as window end -- final cycle counted, shadow loaded with post-update values, -> DONE.
REQ-024 DONE: counters frozen; holds until start.
REQ-025 snap=1 in any state: shadow loads the value each counter takes at that edge; snap coincident with window end/stop gives identical result (one load).
REQ-026 snap and start same edge: shadow loads zeros.
REQ-027 rd_data <= shadow[rd_sel] each edge: 1-cycle latency from rd_sel change or shadow load; rd_sel >= NUM_CH returns 0.
REQ-028 win_cnt wraps silently in unbounded mode; no effect on state.

Reset
REQ-029 reset_n low: state=IDLE, counters, win_cnt, latched win_len, shadow, ovf, rd_data all 0, busy=0, done=0, immediately and independent of clock.
REQ-030 reset_n assertion mid-RUN discards the measurement; first edge after deassertion behaves as IDLE.

Verification
REQ-031 NUM_CH=4, CNT_W=32: start with win_len=10, event=4'b0101 every cycle -> done after 10 counted cycles; rd_sel 0..3 give 10,0,10,0; busy low, done high.
REQ-032 Unbounded window, event[1] pulsed 7 times, stop on cycle 20 coincident with event[1] -> shadow[1]=8, DONE, ovf=0.
REQ-033 CNT_W=8, event[2] held high for 258 cycles then stop -> shadow[2]=2, ovf=4'b0100; next start clears ovf to 0.
REQ-034 snap at 5th RUN cycle with event[0] high all cycles, run continues -> shadow[0]=5 while live counter keeps increasing; rd_data updates one cycle after rd_sel change.
REQ-035 start and stop same edge while RUN -> counters zero, state stays RUN; reset_n pulsed low mid-RUN -> all outputs 0 without a clock edge, state IDLE.
